cpu_bus_ctrl: RTL



---
 rtl/cpu_bus_ctrl_if.sv | 27 ++
 rtl/cpu_bus_ctrl.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/cpu_bus_ctrl_if.sv
// cpu_bus_ctrl_if: CPU-side strobes, decoder selects and the SDRAM
// arbiter handshake seen by cpu_bus_ctrl.
//   slave  : the bus controller (consumes strobes/selects/ack, drives the rest)
//   master : the CPU/decoder/arbiter side
interface cpu_bus_ctrl_if;
    logic       cpu_as_n;     // CPU address strobe, active low
    logic [1:0] cpu_ds_n;     // UDS/LDS, active low
    logic       cpu_rw;       // 1=read, 0=write
    logic [8:0] cs_n;         // decoder selects, active low, [0] highest priority
    logic       mem_req;      // SDRAM request level
    logic       mem_we;       // write flag, valid while mem_req
    logic       mem_region;   // 0=ROM 1=WORK, valid while mem_req
    logic       mem_ack;      // one-cycle acknowledge from arbiter
    logic       cpu_dtack_n;  // DTACK to CPU
    logic       cpu_berr_n;   // BERR to CPU
    logic       busy;         // controller not idle

    modport slave (
        input  cpu_as_n, cpu_ds_n, cpu_rw, cs_n, mem_ack,
        output mem_req, mem_we, mem_region, cpu_dtack_n, cpu_berr_n, busy
    );

    modport master (
        output cpu_as_n, cpu_ds_n, cpu_rw, cs_n, mem_ack,
        input  mem_req, mem_we, mem_region, cpu_dtack_n, cpu_berr_n, busy
    );
endinterface

// File: rtl/cpu_bus_ctrl.sv
// cpu_bus_ctrl: 68000 bus cycle controller behind the address decoder.
// ROM/WORK accesses go through a level req / pulse ack handshake to the
// SDRAM arbiter; other regions complete after a fixed per-region wait;
// strobed accesses with no select time out into a bus error.
// Ports:
//   clk      system clock
//   reset_n  asynchronous active-low reset
//   bus      cpu_bus_ctrl_if.slave (CPU strobes, cs_n, mem handshake,
//            DTACK/BERR, busy). All outputs are registered.
module cpu_bus_ctrl #(
    parameter int unsigned WAIT_VRAM  = 1,
    parameter int unsigned WAIT_IO    = 3,
    parameter int unsigned WAIT_SOUND = 5,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic           clk,
    input  logic           reset_n,
    cpu_bus_ctrl_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE, S_WAIT_CNT, S_WAIT_MEM, S_ACK, S_ABORT, S_UNMAPPED, S_ERR
    } state_t;

    localparam logic [7:0] TIMEOUT_Q = 8'(TIMEOUT);

    state_t     state_q;
    logic [7:0] cnt_q;
    logic       req_q, we_q, region_q, dtack_n_q, berr_n_q, busy_q;

    logic       qual, hit, hit_mem, start;
    logic [3:0] hit_idx, hit_wait;

    // Lowest-index active select wins; descending loop leaves the lowest.
    always_comb begin
        hit_idx = 4'd0;
        for (int i = 8; i >= 0; i--) begin
            if (!bus.cs_n[i]) hit_idx = 4'(i);
        end
        hit     = ~&bus.cs_n;
        hit_mem = (hit_idx[3:1] == 3'd0);
        case (hit_idx)
            4'd5:    hit_wait = 4'(WAIT_IO);
            4'd6:    hit_wait = 4'(WAIT_SOUND);
            default: hit_wait = 4'(WAIT_VRAM);
        endcase
        qual  = !bus.cpu_as_n && !(&bus.cpu_ds_n);
        // A select arriving during the unmapped countdown starts a normal cycle.
        start = qual && hit && (state_q == S_IDLE || state_q == S_UNMAPPED);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= 8'd0;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            region_q  <= 1'b0;
            dtack_n_q <= 1'b1;
            berr_n_q  <= 1'b1;
            busy_q    <= 1'b0;
        end else if (start) begin
            busy_q <= 1'b1;
            if (hit_mem) begin
                state_q  <= S_WAIT_MEM;
                req_q    <= 1'b1;
                we_q     <= !bus.cpu_rw;
                region_q <= hit_idx[0];
            end else if (hit_wait == 4'd0) begin
                state_q   <= S_ACK;
                dtack_n_q <= 1'b0;
            end else begin
                state_q <= S_WAIT_CNT;
                cnt_q   <= {4'd0, hit_wait};
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (qual) begin
                        state_q <= S_UNMAPPED;
                        cnt_q   <= TIMEOUT_Q;
                        busy_q  <= 1'b1;
                    end
                end
                // Count of N gives N cycles here; leaving on 1 lands DTACK at T0+N+1.
                S_WAIT_CNT: begin
                    if (bus.cpu_as_n) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end else if (cnt_q == 8'd1) begin
                        state_q   <= S_ACK;
                        dtack_n_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - 8'd1;
                    end
                end
                S_WAIT_MEM: begin
                    if (bus.mem_ack) begin
                        req_q <= 1'b0;
                        if (bus.cpu_as_n) begin
                            // CPU gave up in the same cycle: finish silently.
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q   <= S_ACK;
                            dtack_n_q <= 1'b0;
                        end
                    end else if (bus.cpu_as_n) begin
                        state_q <= S_ABORT;
                    end
                end
                // The arbiter cannot take a request back, so wait out its ack.
                S_ABORT: begin
                    if (bus.mem_ack) begin
                        req_q   <= 1'b0;
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                S_ACK: begin
                    if (bus.cpu_as_n) begin
                        dtack_n_q <= 1'b1;
                        state_q   <= S_IDLE;
                        busy_q    <= 1'b0;
                    end
                end
                S_UNMAPPED: begin
                    if (bus.cpu_as_n) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end else if (cnt_q == 8'd1) begin
                        state_q  <= S_ERR;
                        berr_n_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - 8'd1;
                    end
                end
                S_ERR: begin
                    if (bus.cpu_as_n) begin
                        berr_n_q <= 1'b1;
                        state_q  <= S_IDLE;
                        busy_q   <= 1'b0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.mem_req     = req_q;
    assign bus.mem_we      = we_q;
    assign bus.mem_region  = region_q;
    assign bus.cpu_dtack_n = dtack_n_q;
    assign bus.cpu_berr_n  = berr_n_q;
    assign bus.busy        = busy_q;

endmodule
